// File: rtl/audio_mix_seq.sv
`default_nettype none
// ============================================================================
// Module   : audio_mix_seq
// Purpose  : Time-shares one signed 8x7 volume multiplier across the four
//            Paula channels and accumulates the 15-bit left/right mix sums.
// Revision : 1.0 - initial release
// ============================================================================
module audio_mix_seq (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sample_en,
    input  logic [3:0]  chen,
    input  logic [7:0]  smp0,
    input  logic [7:0]  smp1,
    input  logic [7:0]  smp2,
    input  logic [7:0]  smp3,
    input  logic [6:0]  vol0,
    input  logic [6:0]  vol1,
    input  logic [6:0]  vol2,
    input  logic [6:0]  vol3,
    output logic [14:0] ldatasum,
    output logic [14:0] rdatasum,
    output logic        busy,
    output logic        done,
    output logic        ovr
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CH0  = 3'd1,
        S_CH1  = 3'd2,
        S_CH2  = 3'd3,
        S_CH3  = 3'd4,
        S_OUT  = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [7:0]  r_smp [4];
    logic [6:0]  r_vol [4];
    logic [3:0]  r_chen;
    logic [14:0] r_lacc;
    logic [14:0] r_racc;
    logic [14:0] r_ldatasum;
    logic [14:0] r_rdatasum;
    logic        r_done;
    logic        r_ovr;

    logic        w_accept;
    logic        w_ch_active;
    logic        w_left;
    logic [1:0]  w_ch;
    logic [7:0]  w_smp;
    logic [6:0]  w_vol_sel;
    logic [6:0]  w_vol_eff;
    logic [13:0] w_mul_a;
    logic [13:0] w_mul_b;
    logic [13:0] w_mul_p;
    logic [14:0] w_term;

    // The OUT cycle can accept a new strobe so passes can run every 5 cycles.
    assign w_accept = sample_en && ((r_state == S_IDLE) || (r_state == S_OUT));

    always_comb begin
        w_state_nxt = r_state;
        w_ch        = 2'd0;
        w_ch_active = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_CH0;
                end
            end
            S_CH0: begin
                w_ch        = 2'd0;
                w_ch_active = 1'b1;
                w_state_nxt = S_CH1;
            end
            S_CH1: begin
                w_ch        = 2'd1;
                w_ch_active = 1'b1;
                w_state_nxt = S_CH2;
            end
            S_CH2: begin
                w_ch        = 2'd2;
                w_ch_active = 1'b1;
                w_state_nxt = S_CH3;
            end
            S_CH3: begin
                w_ch        = 2'd3;
                w_ch_active = 1'b1;
                w_state_nxt = S_OUT;
            end
            S_OUT: begin
                w_state_nxt = w_accept ? S_CH0 : S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Shared multiplier: sign-extended sample times zero-extended clamped volume.
    assign w_smp     = r_smp[w_ch];
    assign w_vol_sel = r_vol[w_ch];
    assign w_vol_eff = w_vol_sel[6] ? 7'd64 : w_vol_sel;
    assign w_mul_a   = {{6{w_smp[7]}}, w_smp};
    assign w_mul_b   = {7'd0, w_vol_eff};
    assign w_mul_p   = w_mul_a * w_mul_b;
    assign w_term    = r_chen[w_ch] ? {w_mul_p[13], w_mul_p} : 15'd0;
    assign w_left    = (w_ch == 2'd0) || (w_ch == 2'd3);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_chen     <= 4'd0;
            r_lacc     <= 15'd0;
            r_racc     <= 15'd0;
            r_ldatasum <= 15'd0;
            r_rdatasum <= 15'd0;
            r_done     <= 1'b0;
            r_ovr      <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_smp[i] <= 8'd0;
                r_vol[i] <= 7'd0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;
            r_ovr   <= sample_en && w_ch_active;

            if (w_accept) begin
                r_smp[0] <= smp0;
                r_smp[1] <= smp1;
                r_smp[2] <= smp2;
                r_smp[3] <= smp3;
                r_vol[0] <= vol0;
                r_vol[1] <= vol1;
                r_vol[2] <= vol2;
                r_vol[3] <= vol3;
                r_chen   <= chen;
                r_lacc   <= 15'd0;
                r_racc   <= 15'd0;
            end else if (w_ch_active) begin
                if (w_left) begin
                    r_lacc <= r_lacc + w_term;
                end else begin
                    r_racc <= r_racc + w_term;
                end
            end

            if (r_state == S_OUT) begin
                r_ldatasum <= r_lacc;
                r_rdatasum <= r_racc;
                r_done     <= 1'b1;
            end
        end
    end

    assign ldatasum = r_ldatasum;
    assign rdatasum = r_rdatasum;
    assign done     = r_done;
    assign ovr      = r_ovr;
    assign busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_audio_mix_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_mix_seq
// Purpose  : Self-checking bench for audio_mix_seq against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_mix_seq;

    logic        clk;
    logic        reset_n;
    logic        sample_en;
    logic [3:0]  tb_chen;
    logic [7:0]  tb_smp [4];
    logic [6:0]  tb_vol [4];
    logic [14:0] ldatasum;
    logic [14:0] rdatasum;
    logic        busy;
    logic        done;
    logic        ovr;

    int n_cmp;
    int n_err;

    audio_mix_seq dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sample_en (sample_en),
        .chen      (tb_chen),
        .smp0      (tb_smp[0]),
        .smp1      (tb_smp[1]),
        .smp2      (tb_smp[2]),
        .smp3      (tb_smp[3]),
        .vol0      (tb_vol[0]),
        .vol1      (tb_vol[1]),
        .vol2      (tb_vol[2]),
        .vol3      (tb_vol[3]),
        .ldatasum  (ldatasum),
        .rdatasum  (rdatasum),
        .busy      (busy),
        .done      (done),
        .ovr       (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int term(input logic [7:0] s, input logic [6:0] v, input logic en);
        int vv;
        vv = (int'(v) > 64) ? 64 : int'(v);
        return en ? int'($signed(s)) * vv : 0;
    endfunction

    task automatic model(output int l, output int r);
        l = term(tb_smp[0], tb_vol[0], tb_chen[0]) + term(tb_smp[3], tb_vol[3], tb_chen[3]);
        r = term(tb_smp[1], tb_vol[1], tb_chen[1]) + term(tb_smp[2], tb_vol[2], tb_chen[2]);
    endtask

    // Strobe for one cycle, then wait (bounded) for done; lat = edges after accept.
    task automatic do_pass(output int lat, output int novr);
        lat  = -1;
        novr = 0;
        sample_en = 1'b1;
        @(posedge clk); #1;
        sample_en = 1'b0;
        if (ovr) novr++;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (ovr) novr++;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic set_all(input logic [7:0] s, input logic [6:0] v, input logic [3:0] c);
        for (int i = 0; i < 4; i++) begin
            tb_smp[i] = s;
            tb_vol[i] = v;
        end
        tb_chen = c;
    endtask

    task automatic test_reset;
        int l, r, lat, novr, ndone;
        reset_n = 1'b0;
        #12;
        n_cmp++; if (ldatasum !== 15'd0) begin n_err++; $display("FAIL reset_ldatasum: got %0d want 0", ldatasum); end
        n_cmp++; if (rdatasum !== 15'd0) begin n_err++; $display("FAIL reset_rdatasum: got %0d want 0", rdatasum); end
        n_cmp++; if ({busy, done, ovr} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {busy, done, ovr}); end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        set_all(8'd50, 7'd10, 4'hF);
        do_pass(lat, novr);
        n_cmp++; if (int'($signed(ldatasum)) !== 1000) begin n_err++; $display("FAIL pre_reset_l: got %0d want 1000", $signed(ldatasum)); end

        // Interrupt a pass after E2 with an asynchronous reset.
        set_all(8'd90, 7'd30, 4'hF);
        sample_en = 1'b1;
        @(posedge clk); #1;
        sample_en = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        n_cmp++; if ({ldatasum, rdatasum} !== 30'd0) begin n_err++; $display("FAIL midpass_reset_sums: got %0d/%0d want 0/0", ldatasum, rdatasum); end
        n_cmp++; if ({busy, done, ovr} !== 3'b000) begin n_err++; $display("FAIL midpass_reset_flags: got %b want 000", {busy, done, ovr}); end
        @(negedge clk);
        reset_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        n_cmp++; if (ndone !== 0) begin n_err++; $display("FAIL reset_no_done: got %0d done pulses want 0", ndone); end

        for (int i = 0; i < 4; i++) begin
            tb_smp[i] = 8'($urandom);
            tb_vol[i] = 7'($urandom);
        end
        tb_chen = 4'hF;
        model(l, r);
        do_pass(lat, novr);
        n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL post_reset_latency: got %0d want 5", lat); end
        n_cmp++; if (int'($signed(ldatasum)) !== l) begin n_err++; $display("FAIL post_reset_l: got %0d want %0d", $signed(ldatasum), l); end
        n_cmp++; if (int'($signed(rdatasum)) !== r) begin n_err++; $display("FAIL post_reset_r: got %0d want %0d", $signed(rdatasum), r); end
    endtask

    task automatic test_full_scale;
        int lat, novr;
        tb_smp[0] = 8'd127;  tb_vol[0] = 7'd64;
        tb_smp[3] = 8'h80;   tb_vol[3] = 7'd64;
        tb_smp[1] = 8'd127;  tb_vol[1] = 7'd64;
        tb_smp[2] = 8'd127;  tb_vol[2] = 7'd64;
        tb_chen   = 4'hF;
        do_pass(lat, novr);
        n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL full_latency: got %0d want 5", lat); end
        n_cmp++; if (int'($signed(ldatasum)) !== -64) begin n_err++; $display("FAIL full_l: got %0d want -64", $signed(ldatasum)); end
        n_cmp++; if (int'($signed(rdatasum)) !== 16256) begin n_err++; $display("FAIL full_r: got %0d want 16256", $signed(rdatasum)); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL full_busy_in_done: got %b want 0", busy); end
    endtask

    task automatic test_neg_clamp;
        int lat, novr;
        set_all(8'h80, 7'd127, 4'hF);
        do_pass(lat, novr);
        n_cmp++; if (int'($signed(ldatasum)) !== -16384) begin n_err++; $display("FAIL neg_l: got %0d want -16384", $signed(ldatasum)); end
        n_cmp++; if (int'($signed(rdatasum)) !== -16384) begin n_err++; $display("FAIL neg_r: got %0d want -16384", $signed(rdatasum)); end
    endtask

    task automatic test_mask;
        int lat, novr;
        set_all(8'd100, 7'd64, 4'b0101);
        tb_vol[0] = 7'd32;
        tb_vol[2] = 7'd0;
        do_pass(lat, novr);
        n_cmp++; if (int'($signed(ldatasum)) !== 3200) begin n_err++; $display("FAIL mask_l: got %0d want 3200", $signed(ldatasum)); end
        n_cmp++; if (int'($signed(rdatasum)) !== 0) begin n_err++; $display("FAIL mask_r: got %0d want 0", $signed(rdatasum)); end
    endtask

    task automatic test_random;
        int l, r, lat, novr;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 4; i++) begin
                tb_smp[i] = 8'($urandom);
                tb_vol[i] = 7'($urandom_range(0, 127));
            end
            tb_chen = 4'($urandom);
            model(l, r);
            do_pass(lat, novr);
            n_cmp++; if (int'($signed(ldatasum)) !== l) begin n_err++; $display("FAIL rand_l[%0d]: got %0d want %0d", k, $signed(ldatasum), l); end
            n_cmp++; if (int'($signed(rdatasum)) !== r) begin n_err++; $display("FAIL rand_r[%0d]: got %0d want %0d", k, $signed(rdatasum), r); end
        end
    endtask

    task automatic test_capture_overrun;
        int l, r, lat, novr;
        for (int i = 0; i < 4; i++) begin
            tb_smp[i] = 8'($urandom);
            tb_vol[i] = 7'($urandom_range(1, 64));
        end
        tb_vol[0] = 7'd40;
        tb_chen   = 4'hF;
        model(l, r);
        sample_en = 1'b1;
        @(posedge clk); #1;                       // after E0
        sample_en = 1'b0;
        tb_smp[0] = tb_smp[0] ^ 8'h55;
        @(posedge clk); #1;                       // after E1
        tb_smp[0] = tb_smp[0] ^ 8'h0F;
        tb_vol[0] = 7'd3;
        @(posedge clk); #1;                       // after E2
        sample_en = 1'b1;
        @(posedge clk); #1;                       // after E3
        sample_en = 1'b0;
        n_cmp++; if (ovr !== 1'b1) begin n_err++; $display("FAIL ovr_pulse: got %b want 1", ovr); end
        @(posedge clk); #1;                       // after E4
        n_cmp++; if ({ovr, done} !== 2'b00) begin n_err++; $display("FAIL ovr_single: got ovr,done=%b want 00", {ovr, done}); end
        @(posedge clk); #1;                       // after E5
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL capture_done: got %b want 1", done); end
        n_cmp++; if (int'($signed(ldatasum)) !== l) begin n_err++; $display("FAIL capture_l: got %0d want %0d", $signed(ldatasum), l); end
        n_cmp++; if (int'($signed(rdatasum)) !== r) begin n_err++; $display("FAIL capture_r: got %0d want %0d", $signed(rdatasum), r); end

        // Strobe in the done cycle must be accepted without an overrun.
        for (int i = 0; i < 4; i++) tb_smp[i] = 8'($urandom);
        model(l, r);
        do_pass(lat, novr);
        n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL donecycle_latency: got %0d want 5", lat); end
        n_cmp++; if (novr !== 0) begin n_err++; $display("FAIL donecycle_ovr: got %0d pulses want 0", novr); end
        n_cmp++; if (int'($signed(ldatasum)) !== l) begin n_err++; $display("FAIL donecycle_l: got %0d want %0d", $signed(ldatasum), l); end
    endtask

    task automatic test_back_to_back;
        int q_l[$];
        int q_r[$];
        int q_t[$];
        int l, r, el, er, et, ndone, novr;
        ndone = 0;
        novr  = 0;
        for (int t = 0; t < 40; t++) begin
            if (t < 30 && (t % 5) == 0) begin
                for (int i = 0; i < 4; i++) begin
                    tb_smp[i] = 8'(t * 3 + i * 40 - 100);
                    tb_vol[i] = 7'($urandom_range(0, 127));
                end
                tb_chen = 4'hF;
                model(l, r);
                q_l.push_back(l);
                q_r.push_back(r);
                q_t.push_back(t + 5);
                sample_en = 1'b1;
            end else begin
                sample_en = 1'b0;
            end
            @(posedge clk); #1;
            if (ovr) novr++;
            if (done) begin
                ndone++;
                n_cmp++;
                if (q_l.size() == 0) begin
                    n_err++;
                    $display("FAIL b2b_extra_done: got done at %0d want none", t);
                end else begin
                    el = q_l.pop_front();
                    er = q_r.pop_front();
                    et = q_t.pop_front();
                    if (t !== et) begin n_err++; $display("FAIL b2b_timing: got %0d want %0d", t, et); end
                    n_cmp++; if (int'($signed(ldatasum)) !== el) begin n_err++; $display("FAIL b2b_l: got %0d want %0d", $signed(ldatasum), el); end
                    n_cmp++; if (int'($signed(rdatasum)) !== er) begin n_err++; $display("FAIL b2b_r: got %0d want %0d", $signed(rdatasum), er); end
                end
            end
        end
        sample_en = 1'b0;
        n_cmp++; if (ndone !== 6) begin n_err++; $display("FAIL b2b_done_count: got %0d want 6", ndone); end
        n_cmp++; if (novr !== 0) begin n_err++; $display("FAIL b2b_ovr: got %0d pulses want 0", novr); end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset_n   = 1'b0;
        sample_en = 1'b0;
        set_all(8'd0, 7'd0, 4'h0);
        test_reset();
        test_full_scale();
        test_neg_clamp();
        test_mask();
        test_random();
        test_capture_overrun();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
